instruction_fetch: RTL

- Instruction-fetch stage of the MIPS pipeline. It holds the PC, the instruction memory and its program-load port.
- Each cycle it produces {pc, pc+4, instruction, valid} for the IF/ID pipeline register. o_valid drives that register's enable.
- It takes redirect requests from branch/jump resolution and stall requests from the hazard unit.
- It detects the HALT word and stops fetching.

---
 rtl/instruction_fetch.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// MIPS instruction-fetch stage: PC, instruction memory with program-load
// port, redirect/stall handling and HALT detection feeding IF/ID.
module instruction_fetch #(
    parameter int                  BUS_DATA  = 32,
    parameter int                  BUS_ADDR  = 32,
    parameter int                  MEM_DEPTH = 256,
    parameter logic [BUS_DATA-1:0] HALT_WORD = 32'hFFFFFFFF,
    localparam int                 AW        = $clog2(MEM_DEPTH)
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_enable,
    input  logic                i_stall,
    input  logic                i_pc_src,
    input  logic [BUS_ADDR-1:0] i_pc_target,
    input  logic                i_mem_wr_en,
    input  logic [AW-1:0]       i_mem_wr_addr,
    input  logic [BUS_DATA-1:0] i_mem_wr_data,
    output logic [BUS_ADDR-1:0] o_pc,
    output logic [BUS_ADDR-1:0] o_pc_plus4,
    output logic [BUS_DATA-1:0] o_instruction,
    output logic                o_valid,
    output logic                o_halted
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t              r_state;
    logic [BUS_ADDR-1:0] r_pc;
    logic [BUS_ADDR-1:0] r_opc;
    logic [BUS_ADDR-1:0] r_opc4;
    logic [BUS_DATA-1:0] r_ins;
    logic                r_valid;
    logic                r_halted;
    logic [BUS_DATA-1:0] r_mem [MEM_DEPTH];

    state_t              w_state_nx;
    logic [BUS_ADDR-1:0] w_pc_nx;
    logic [BUS_ADDR-1:0] w_opc_nx;
    logic [BUS_ADDR-1:0] w_opc4_nx;
    logic [BUS_DATA-1:0] w_ins_nx;
    logic                w_valid_nx;
    logic                w_halted_nx;
    logic                w_mem_we;

    logic [BUS_ADDR-1:0] w_pc_plus4;
    logic [BUS_ADDR-1:0] w_target;
    logic                w_in_range;
    logic [BUS_DATA-1:0] w_fetch_word;
    logic                w_is_halt;

    assign w_pc_plus4 = r_pc + BUS_ADDR'(4);
    assign w_target   = i_pc_target & {{(BUS_ADDR-2){1'b1}}, 2'b00};

    // Any word index beyond the memory reads as HALT so a runaway PC stops
    assign w_in_range   = ~|r_pc[BUS_ADDR-1:AW+2];
    assign w_fetch_word = w_in_range ? r_mem[r_pc[2+:AW]] : HALT_WORD;
    assign w_is_halt    = (w_fetch_word == HALT_WORD);

    always_comb begin
        w_state_nx  = r_state;
        w_pc_nx     = r_pc;
        w_opc_nx    = r_opc;
        w_opc4_nx   = r_opc4;
        w_ins_nx    = r_ins;
        w_valid_nx  = r_valid;
        w_halted_nx = r_halted;
        w_mem_we    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_mem_we   = i_mem_wr_en;
                w_valid_nx = 1'b0;
                if (i_start) begin
                    w_state_nx = ST_RUN;
                    w_pc_nx    = '0;
                end
            end
            ST_RUN: begin
                if (i_enable) begin
                    if (i_pc_src) begin
                        w_pc_nx    = w_target;
                        w_valid_nx = 1'b0;
                    end else if (!i_stall) begin
                        w_ins_nx   = w_fetch_word;
                        w_opc_nx   = r_pc;
                        w_opc4_nx  = w_pc_plus4;
                        w_valid_nx = 1'b1;
                        if (w_is_halt) begin
                            w_state_nx  = ST_HALTED;
                            w_halted_nx = 1'b1;
                        end else begin
                            w_pc_nx = w_pc_plus4;
                        end
                    end
                end
            end
            ST_HALTED: begin
                if (i_enable) begin
                    w_valid_nx = 1'b0;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= ST_IDLE;
            r_pc     <= '0;
            r_opc    <= '0;
            r_opc4   <= '0;
            r_ins    <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_pc     <= w_pc_nx;
            r_opc    <= w_opc_nx;
            r_opc4   <= w_opc4_nx;
            r_ins    <= w_ins_nx;
            r_valid  <= w_valid_nx;
            r_halted <= w_halted_nx;
        end
    end

    // Program storage survives reset so a loaded program can be rerun
    always_ff @(posedge i_clock) begin
        if (w_mem_we) begin
            r_mem[i_mem_wr_addr] <= i_mem_wr_data;
        end
    end

    assign o_pc          = r_opc;
    assign o_pc_plus4    = r_opc4;
    assign o_instruction = r_ins;
    assign o_valid       = r_valid;
    assign o_halted      = r_halted;

endmodule
